// File: rtl/mul_sequencer.sv
// Issue/sequencing controller wrapping an unsigned 32x32 iterative multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Miss: LATENCY+2 cycles accept-to-result, hit on the 64-bit product cache: 1 cycle; req_ready only in IDLE, result held until resp_ready.
module mul_sequencer #(
  parameter int LATENCY = 6,
  parameter int XLEN    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_funct3,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              busy,
  output logic [XLEN-1:0]   mul_op1,
  output logic [XLEN-1:0]   mul_op2,
  input  logic [2*XLEN-1:0] mul_answer
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIX  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // operation in flight
  logic [3:0]        r_cnt;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [4:0]        r_rd;
  logic              r_is_mul;
  logic              r_neg;
  logic [XLEN-1:0]   r_k_rs1;
  logic [XLEN-1:0]   r_k_rs2;
  logic              r_k_s1;
  logic              r_k_s2;
  logic [2*XLEN-1:0] r_answer;

  // product cache
  logic              r_c_vld;
  logic [XLEN-1:0]   r_c_rs1;
  logic [XLEN-1:0]   r_c_rs2;
  logic              r_c_s1;
  logic              r_c_s2;
  logic [2*XLEN-1:0] r_c_prod;

  // response
  logic              r_resp_vld;
  logic [XLEN-1:0]   r_resp_data;
  logic [4:0]        r_resp_rd;

  logic              w_s1;
  logic              w_s2;
  logic              w_neg;
  logic [XLEN-1:0]   w_a1;
  logic [XLEN-1:0]   w_a2;
  logic              w_key_match;
  logic              w_hit;
  logic              w_accept;
  logic              w_cnt_done;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_hit_data;
  logic [XLEN-1:0]   w_fix_data;

  assign w_s1 = (req_funct3 != 2'b11);
  assign w_s2 = ~req_funct3[1];

  // Two's-complement negate also maps 0x80000000 to itself, which is the correct unsigned magnitude.
  assign w_a1  = (w_s1 & req_rs1[XLEN-1]) ? -req_rs1 : req_rs1;
  assign w_a2  = (w_s2 & req_rs2[XLEN-1]) ? -req_rs2 : req_rs2;
  assign w_neg = (w_s1 & req_rs1[XLEN-1]) ^ (w_s2 & req_rs2[XLEN-1]);

  // The low word of a product does not depend on signedness, so MUL may reuse any cached entry.
  assign w_key_match = (req_rs1 == r_c_rs1) && (req_rs2 == r_c_rs2);
  assign w_hit = r_c_vld && w_key_match &&
                 ((req_funct3 == 2'b00) || ((w_s1 == r_c_s1) && (w_s2 == r_c_s2)));

  assign w_accept   = req_valid && (r_state == S_IDLE) && !flush;
  assign w_cnt_done = (r_cnt == 4'(LATENCY - 1));

  assign w_prod     = r_neg ? -r_answer : r_answer;
  assign w_hit_data = (req_funct3 == 2'b00) ? r_c_prod[XLEN-1:0] : r_c_prod[2*XLEN-1:XLEN];
  assign w_fix_data = r_is_mul ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_hit ? S_RESP : S_WAIT;
      S_WAIT:  if (w_cnt_done) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_rd        <= 5'd0;
      r_is_mul    <= 1'b0;
      r_neg       <= 1'b0;
      r_k_rs1     <= '0;
      r_k_rs2     <= '0;
      r_k_s1      <= 1'b0;
      r_k_s2      <= 1'b0;
      r_answer    <= '0;
      r_c_vld     <= 1'b0;
      r_c_rs1     <= '0;
      r_c_rs2     <= '0;
      r_c_s1      <= 1'b0;
      r_c_s2      <= 1'b0;
      r_c_prod    <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_data <= '0;
      r_resp_rd   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_hit) begin
            r_resp_vld  <= 1'b1;
            r_resp_data <= w_hit_data;
            r_resp_rd   <= req_rd;
          end else if (w_accept) begin
            r_op1    <= w_a1;
            r_op2    <= w_a2;
            r_rd     <= req_rd;
            r_is_mul <= (req_funct3 == 2'b00);
            r_neg    <= w_neg;
            r_k_rs1  <= req_rs1;
            r_k_rs2  <= req_rs2;
            r_k_s1   <= w_s1;
            r_k_s2   <= w_s2;
            r_cnt    <= 4'd0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_cnt_done) begin
            r_answer <= mul_answer;
          end
        end
        S_FIX: begin
          r_c_vld     <= 1'b1;
          r_c_rs1     <= r_k_rs1;
          r_c_rs2     <= r_k_rs2;
          r_c_s1      <= r_k_s1;
          r_c_s2      <= r_k_s2;
          r_c_prod    <= w_prod;
          r_resp_vld  <= 1'b1;
          r_resp_data <= w_fix_data;
          r_resp_rd   <= r_rd;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_vld <= 1'b0;
          end
        end
        default: ;
      endcase
      // A kill drops any pending result and distrusts the cache; the multiplier inputs are left alone.
      if (flush) begin
        r_resp_vld <= 1'b0;
        r_c_vld    <= 1'b0;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = r_resp_vld;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign mul_op1    = r_op1;
  assign mul_op2    = r_op2;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer against a signed-arithmetic reference and a key-level cache model.
module tb_mul_sequencer;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] mul_answer;

  always #5 clk = ~clk;

  mul_sequencer #(.LATENCY(LAT), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .busy       (busy),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_answer (mul_answer)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Multiplier model: the product is only correct once the inputs have been stable for LAT-1 falling edges.
  logic [7:0]  age = 8'd0;
  logic [31:0] pm1 = 32'd0;
  logic [31:0] pm2 = 32'd0;
  always @(negedge clk) begin
    if (mul_op1 !== pm1 || mul_op2 !== pm2) age = 8'd0;
    else if (age != 8'hFF) age = age + 8'd1;
    pm1 = mul_op1;
    pm2 = mul_op2;
    mul_answer = (int'(age) >= LAT - 1) ? ({32'd0, mul_op1} * {32'd0, mul_op2}) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Reference cache: key of the last completed, un-flushed miss.
  bit          m_vld = 1'b0;
  logic [31:0] m_a, m_b;
  bit          m_s1, m_s2;

  function automatic logic [31:0] ref_result(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      x, y;
    logic [63:0] p;
    x = (f3 != 2'b11) ? longint'(signed'(a)) : longint'({32'd0, a});
    y = (f3[1] == 1'b0) ? longint'(signed'(b)) : longint'({32'd0, b});
    p = 64'(x * y);
    return (f3 == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input bit s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  // mode 0: normal, 1: flush in 2nd WAIT cycle, 2: flush while result is pending
  task automatic run_op(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input int mode);
    bit          s1, s2, hit, ops_ok, quiet, stable;
    logic [31:0] exp, e1, e2;
    int          n;
    s1  = (f3 != 2'b11);
    s2  = !f3[1];
    hit = m_vld && a == m_a && b == m_b && (f3 == 2'b00 || (s1 == m_s1 && s2 == m_s2));
    exp = ref_result(f3, a, b);
    e1  = hit ? mul_op1 : mag(a, s1);
    e2  = hit ? mul_op2 : mag(b, s2);
    resp_ready = (hold == 0 && mode != 2);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("req_ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    ops_ok = 1'b1;
    while (!resp_valid && n < LAT + 10) begin
      if (mul_op1 !== e1 || mul_op2 !== e2) ops_ok = 1'b0;
      if (mode == 1 && n == 2) break;
      @(negedge clk); n++;
    end
    check_eq("ops_stable_in_wait", 64'(ops_ok), 64'd1);
    if (mode == 1) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_wait_state", {61'd0, resp_valid, busy, req_ready}, 64'd1);
      quiet = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
        @(negedge clk);
        if (resp_valid) quiet = 1'b0;
      end
      check_eq("flush_wait_no_resp", 64'(quiet), 64'd1);
      check_eq("flush_wait_ops_kept", {mul_op1, mul_op2}, {e1, e2});
      m_vld = 1'b0;
      resp_ready = 1'b1;
      return;
    end
    check_eq("latency", 64'(n), hit ? 64'd1 : 64'(LAT + 2));
    check_eq("resp_data", 64'(resp_data), 64'(exp));
    check_eq("resp_rd", 64'(resp_rd), 64'(rd));
    check_eq("mul_ops", {mul_op1, mul_op2}, {e1, e2});
    if (!hit) begin
      m_vld = 1'b1; m_a = a; m_b = b; m_s1 = s1; m_s2 = s2;
    end
    if (mode == 2) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_resp_state", {61'd0, resp_valid, busy, req_ready}, 64'd1);
      m_vld = 1'b0;
      resp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      req_valid = 1'b1; req_funct3 = ~f3; req_rs1 = ~a; req_rs2 = b + 32'd1; req_rd = ~rd;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (resp_data !== exp || resp_rd !== rd || !resp_valid || req_ready) stable = 1'b0;
      end
      check_eq("backpressure_hold", 64'(stable), 64'd1);
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("retire_state", {61'd0, resp_valid, busy, req_ready}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b1; req_valid = 1'b0; req_funct3 = 2'b00; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush = 1'b0; resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check_eq("reset_outputs", {resp_valid, busy, req_ready, resp_rd, resp_data},
             {1'b0, 1'b0, 1'b1, 5'd0, 32'd0});
    check_eq("reset_ops", {mul_op1, mul_op2}, 64'd0);
    #19 rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 5'd10, 0, 0);
    run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 5, 0);
    run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 5'd12, 0, 0);
    run_op(2'b11, 32'h0000_1234, 32'h0000_5678, 5'd13, 0, 1);
    run_op(2'b11, 32'h0000_1234, 32'h0000_5678, 5'd14, 0, 0);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0055, 5'd15, 0, 2);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0055, 5'd16, 0, 0);

    // Asynchronous reset in the middle of WAIT.
    req_valid = 1'b1; req_funct3 = 2'b11; req_rs1 = 32'h0BAD_F00D; req_rs2 = 32'h0000_0777; req_rd = 5'd20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midwait_reset_outputs", {resp_valid, busy, req_ready, resp_rd, resp_data},
             {1'b0, 1'b0, 1'b1, 5'd0, 32'd0});
    check_eq("midwait_reset_ops", {mul_op1, mul_op2}, 64'd0);
    m_vld = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 32'd7, 32'd6, 5'd21, 0, 0);
    check_eq("mul_7x6", 64'(resp_data), 64'h2A);

    a = 32'd3; b = 32'd5;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        a = pick();
        b = pick();
      end
      run_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Issue/sequencing controller for the unsigned 32x32 iterative multiplier in the RV32M execute stage.
- Accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and converts signed operands to magnitudes.
- Holds the multiplier inputs stable for the full iteration, waits a fixed latency, applies sign correction and selects the high or low word.
- Caches the last 64-bit product so a MULH-then-MUL pair on the same operands returns the second result in one cycle.

Parameters:
- LATENCY, 6: cycles the multiplier inputs are held before mul_answer is sampled (must be ≥ the multiplier's restart-to-answer time; legal range 1..15).
- XLEN, 32: operand width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; equals (state==IDLE)
- req_funct3  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- req_rd  in  5  destination tag, returned with the result
- flush  in  1  pipeline kill; aborts any in-flight operation
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_data  out  32  result word
- resp_rd  out  5  tag of the result
- busy  out  1  state != IDLE
- mul_op1  out  32  multiplier operand 1 (registered)
- mul_op2  out  32  multiplier operand 2 (registered)
- mul_answer  in  64  unsigned product from the multiplier

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - resp_valid=0, resp_data=0, resp_rd=0, mul_op1=0, mul_op2=0, busy=0, req_ready=1, cache invalid.
- Handshakes:
  - Request accepted on a rising edge with req_valid & req_ready.
  - Response retired on a rising edge with resp_valid & resp_ready.
  - resp_data and resp_rd are held stable while resp_valid=1 and resp_ready=0.
- Signedness per funct3:
  - s1 = funct3 ∈ {00, 01, 10}; s2 = funct3 ∈ {00, 01}.
  - MUL uses the signed-signed path; its low word is signedness-independent.
- Magnitude:
  - a1 = (s1 & rs1[31]) ? -rs1 : rs1, computed mod 2^32; likewise a2.
  - neg = (s1 & rs1[31]) ^ (s2 & rs2[31]).
  - 0x80000000 yields magnitude 0x80000000.
- Cache key: {rs1, rs2, s1, s2} of the last completed miss. Hit rules:
  - MUL hits when the rs1/rs2 match and the cache is valid, regardless of s1/s2.
  - Other ops need an exact key match.
- FSM:
  - IDLE: on accept with a hit, load resp_* from the cached 64-bit signed product P (P[31:0] for MUL, else P[63:32]) and go to RESP.
  - IDLE: on accept with a miss, register a1/a2 onto mul_op1/mul_op2, latch rd/funct3/neg/key, clear the counter, and go to WAIT.
  - WAIT: mul_op1/mul_op2 held constant. The counter increments each cycle. When counter==LATENCY-1, capture mul_answer and go to FIX.
  - FIX: P = neg ? -answer : answer (64-bit two's complement). Write P and the key into the cache, set it valid, load resp_*, go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE; resp_valid drops the following cycle.
  - A new request is accepted only in IDLE, so there is no accept-and-retire in the same cycle.
- Latency:
  - Miss: accept edge to resp_valid = LATENCY+2 cycles.
  - Hit: 1 cycle.
- mul_op1/mul_op2 keep their last values in IDLE/FIX/RESP. They change only on a miss accept, so the multiplier restarts only when required.
- flush:
  - Takes priority over everything, including an accept in the same cycle.
  - Next state IDLE, resp_valid=0, cache invalidated, mul_op* unchanged.
  - A flush while in RESP discards the pending result.
- Counter width: 4 bits. No wrap-around is possible within the legal LATENCY range.

Test Plan:
1. Reset, then MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF with resp_ready=1 → resp_data=0xFFFFFFFE, resp_valid exactly LATENCY+2 cycles after accept; mul_op1/mul_op2 stable throughout WAIT.
2. Next MUL with the same operands → cache hit: resp_data=0x00000001 one cycle after accept, mul_op* unchanged. Then MULH with the same operands → miss (key differs), mul_op1=mul_op2=0x00000001, resp_data=0x00000000.
3. MULHSU rs1=0xFFFFFFFF rs2=0xFFFFFFFF → 0xFFFFFFFF. MULH 0x80000000×0x80000000 → 0x40000000. MUL 0xFFFFFFFE×0x00000003 → 0xFFFFFFFA.
4. Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_data/resp_rd stable, req_ready=0, a held req_valid is not accepted. Then resp_ready=1 → retire, then accept next.
5. flush asserted in the 2nd WAIT cycle, and separately in RESP → IDLE next cycle, no resp_valid. Repeating the prior operands must miss, because the cache was invalidated.
6. rst_n pulsed low asynchronously (off-edge) mid-WAIT → all outputs at reset values immediately, then a fresh MUL 7×6 returns 42 (0x0000002A), tag preserved.
